// File: rtl/lc3_isdu_pkg.sv
// Shared types and encodings for the LC-3 instruction sequencer/decoder.
// The PAUSE states exist only when ISDU_PAUSE_EN is defined.
package isdu_pkg;

  typedef enum logic [4:0] {
    S_HALTED = 5'd0,
    S_18     = 5'd1,
    S_33     = 5'd2,
    S_35     = 5'd3,
    S_32     = 5'd4,
    S_01     = 5'd5,
    S_05     = 5'd6,
    S_09     = 5'd7,
    S_00     = 5'd8,
    S_22     = 5'd9,
    S_12     = 5'd10,
    S_04     = 5'd11,
    S_06     = 5'd12,
    S_07     = 5'd13,
    S_25     = 5'd14,
    S_27     = 5'd15,
    S_23     = 5'd16,
    S_16     = 5'd17
`ifdef ISDU_PAUSE_EN
    , S_PAUSE1 = 5'd18,
    S_PAUSE2 = 5'd19
`endif
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_BUS  = 2'b10;

  localparam logic [1:0] ADDR2_OFF11 = 2'b00;
  localparam logic [1:0] ADDR2_OFF9  = 2'b01;
  localparam logic [1:0] ADDR2_OFF6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO  = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  // States that hold a memory enable for MEM_WAIT cycles.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/lc3_isdu_if.sv
// Control/feedback bundle between the LC-3 sequencer (master) and datapath (slave).
interface lc3_isdu_if;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       GateMDR, GateALU, GatePC, GateMARMUX;
  logic       LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG, LD_LED;
  logic [1:0] PCMUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic       MIO_EN, Mem_OE, Mem_WE;

  modport master (
    input  Opcode, IR_5, IR_11, BEN,
    output GateMDR, GateALU, GatePC, GateMARMUX,
    output LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG, LD_LED,
    output PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
    output MIO_EN, Mem_OE, Mem_WE
  );

  modport slave (
    output Opcode, IR_5, IR_11, BEN,
    input  GateMDR, GateALU, GatePC, GateMARMUX,
    input  LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG, LD_LED,
    input  PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
    input  MIO_EN, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_isdu_wait_ctr.sv
// Memory wait counter: 3-bit, clear has priority, saturates at MEM_WAIT-1 via done.
module isdu_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset_al,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] count_r;

  // Count cycles spent in a memory wait state.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      count_r <= 3'd0;
    end else if (clr) begin
      count_r <= 3'd0;
    end else if (en) begin
      count_r <= count_r + 3'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == LAST);

endmodule

// File: rtl/lc3_isdu.sv
// LC-3 instruction sequencer/decoder: fetch/decode/execute FSM with Moore control outputs.
// Optional PAUSE instruction (opcode 1101) enabled by defining ISDU_PAUSE_EN.
module lc3_isdu
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_al,
  input  logic       Run,
  input  logic       Continue,
  lc3_isdu_if.master dp
);

  state_t state_r;
  state_t next_s;
  logic   in_wait_s;
  logic   done_s;
  logic   ctr_clr_s;
  logic   ctr_en_s;

  assign in_wait_s = is_mem_wait(state_r);
  assign ctr_clr_s = ~in_wait_s | done_s;
  assign ctr_en_s  = in_wait_s & ~done_s;

  isdu_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait_ctr (
    .Clk      (Clk),
    .Reset_al (Reset_al),
    .clr      (ctr_clr_s),
    .en       (ctr_en_s),
    .done     (done_s)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state_r <= S_HALTED;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_HALTED: begin
        if (Run) next_s = S_18;
        else     next_s = S_HALTED;
      end
      S_18: next_s = S_33;
      S_33: begin
        if (done_s) next_s = S_35;
        else        next_s = S_33;
      end
      S_35: next_s = S_32;
      S_32: begin
        case (dp.Opcode)
          OP_ADD:   next_s = S_01;
          OP_AND:   next_s = S_05;
          OP_NOT:   next_s = S_09;
          OP_BR:    next_s = S_00;
          OP_JMP:   next_s = S_12;
          OP_JSR:   next_s = S_04;
          OP_LDR:   next_s = S_06;
          OP_STR:   next_s = S_07;
`ifdef ISDU_PAUSE_EN
          OP_PAUSE: next_s = S_PAUSE1;
`endif
          default:  next_s = S_18;
        endcase
      end
      S_01, S_05, S_09: next_s = S_18;
      S_00: begin
        if (dp.BEN) next_s = S_22;
        else        next_s = S_18;
      end
      S_22, S_12, S_04: next_s = S_18;
      S_06: next_s = S_25;
      S_07: next_s = S_23;
      S_25: begin
        if (done_s) next_s = S_27;
        else        next_s = S_25;
      end
      S_27: next_s = S_18;
      S_23: next_s = S_16;
      S_16: begin
        if (done_s) next_s = S_18;
        else        next_s = S_16;
      end
`ifdef ISDU_PAUSE_EN
      S_PAUSE1: begin
        if (Continue) next_s = S_PAUSE2;
        else          next_s = S_PAUSE1;
      end
      S_PAUSE2: begin
        if (Continue) next_s = S_PAUSE2;
        else          next_s = S_18;
      end
`endif
      default: next_s = S_HALTED;
    endcase
  end

  // Moore control decode; everything not named for a state stays 0.
  always_comb begin
    dp.GateMDR    = 1'b0;
    dp.GateALU    = 1'b0;
    dp.GatePC     = 1'b0;
    dp.GateMARMUX = 1'b0;
    dp.LD_MAR     = 1'b0;
    dp.LD_MDR     = 1'b0;
    dp.LD_IR      = 1'b0;
    dp.LD_PC      = 1'b0;
    dp.LD_CC      = 1'b0;
    dp.LD_BEN     = 1'b0;
    dp.LD_REG     = 1'b0;
    dp.PCMUX      = PCMUX_PC1;
    dp.ADDR2MUX   = ADDR2_OFF11;
    dp.ALUK       = ALUK_ADD;
    dp.DRMUX      = 1'b0;
    dp.SR1MUX     = 1'b0;
    dp.SR2MUX     = 1'b0;
    dp.ADDR1MUX   = 1'b0;
    dp.MIO_EN     = 1'b0;
    dp.Mem_OE     = 1'b0;
    dp.Mem_WE     = 1'b0;
    case (state_r)
      S_18: begin
        dp.GatePC = 1'b1;
        dp.LD_MAR = 1'b1;
        dp.PCMUX  = PCMUX_PC1;
        dp.LD_PC  = 1'b1;
      end
      S_33, S_25: begin
        dp.Mem_OE = 1'b1;
        dp.MIO_EN = 1'b1;
        dp.LD_MDR = done_s;
      end
      S_35: begin
        dp.GateMDR = 1'b1;
        dp.LD_IR   = 1'b1;
      end
      S_32: dp.LD_BEN = 1'b1;
      S_01, S_05, S_09: begin
        dp.SR1MUX  = 1'b1;
        dp.SR2MUX  = ~dp.IR_5;
        dp.GateALU = 1'b1;
        dp.LD_REG  = 1'b1;
        dp.LD_CC   = 1'b1;
        if (state_r == S_05)      dp.ALUK = ALUK_AND;
        else if (state_r == S_09) dp.ALUK = ALUK_NOT;
        else                      dp.ALUK = ALUK_ADD;
      end
      S_22: begin
        dp.ADDR2MUX = ADDR2_OFF9;
        dp.PCMUX    = PCMUX_ADDR;
        dp.LD_PC    = 1'b1;
      end
      S_12: begin
        dp.SR1MUX   = 1'b1;
        dp.ADDR1MUX = 1'b1;
        dp.ADDR2MUX = ADDR2_ZERO;
        dp.PCMUX    = PCMUX_ADDR;
        dp.LD_PC    = 1'b1;
      end
      S_04: begin
        // R7 and PC load on the same edge, so JSRR R7 targets the old R7.
        dp.GatePC = 1'b1;
        dp.DRMUX  = 1'b1;
        dp.LD_REG = 1'b1;
        dp.PCMUX  = PCMUX_ADDR;
        dp.LD_PC  = 1'b1;
        dp.SR1MUX = 1'b1;
        if (dp.IR_11) begin
          dp.ADDR1MUX = 1'b0;
          dp.ADDR2MUX = ADDR2_OFF11;
        end else begin
          dp.ADDR1MUX = 1'b1;
          dp.ADDR2MUX = ADDR2_ZERO;
        end
      end
      S_06, S_07: begin
        dp.SR1MUX     = 1'b1;
        dp.ADDR1MUX   = 1'b1;
        dp.ADDR2MUX   = ADDR2_OFF6;
        dp.GateMARMUX = 1'b1;
        dp.LD_MAR     = 1'b1;
      end
      S_27: begin
        dp.GateMDR = 1'b1;
        dp.LD_REG  = 1'b1;
        dp.LD_CC   = 1'b1;
      end
      S_23: begin
        dp.ALUK    = ALUK_PASS;
        dp.GateALU = 1'b1;
        dp.LD_MDR  = 1'b1;
      end
      S_16: dp.Mem_WE = 1'b1;
      default: dp.LD_BEN = 1'b0;
    endcase
  end

`ifdef ISDU_PAUSE_EN
  logic led_shown_r;

  // Remembers that the LED load already fired in this PAUSE1 visit.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      led_shown_r <= 1'b0;
    end else if (state_r == S_PAUSE1) begin
      led_shown_r <= 1'b1;
    end else begin
      led_shown_r <= 1'b0;
    end
  end

  assign dp.LD_LED = (state_r == S_PAUSE1) & ~led_shown_r;
`else
  logic unused_s;
  assign unused_s  = Continue;
  assign dp.LD_LED = 1'b0;
`endif

endmodule
